fetch_line_sequencer: RTL

Refill controller for the fetch window's two 16-byte line ports. It sits between the walking fetch window and a single-ported instruction memory. It holds two tagged line slots and returns any requested line that is resident in the same cycle. Missing lines are fetched one at a time over a valid/ready request channel, and responses already in flight when a redirect arrives are discarded.

---
 rtl/fetch_line_sequencer_pkg.sv | 19 +
 rtl/fetch_line_sequencer_line_slot.sv | 55 +++++
 rtl/fetch_line_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_line_sequencer_pkg.sv
// Shared definitions for the fetch line sequencer.
//   fetch_line_sequencer_cfg_pkg : line geometry shared with the fetch window.
//   fetch_line_sequencer_pkg     : refill state machine encoding.
package fetch_line_sequencer_cfg_pkg;
  localparam int LINE_BYTES  = 16;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int TAG_BITS    = 32 - OFFSET_BITS;
  localparam int LINE_BITS   = LINE_BYTES * 8;
endpackage

package fetch_line_sequencer_pkg;
  typedef enum logic [2:0] {
    FetchIdle,
    FetchRequest,
    FetchWait,
    FetchKill,
    FetchDrain
  } FetchState;
endpackage

// File: rtl/fetch_line_sequencer_line_slot.sv
// line_slot: one tagged line register with write, invalidate and two tag comparators.
// Latency: write/invalidate take effect at the next edge; hit outputs are combinational.
// Backpressure: none; invalidate has priority over write in the same cycle.
// Ports: clock/reset, write_en/write_tag/write_data, invalidate, cmp_tag_a/b -> hit_a/b,
//        valid and data of the stored line.
module line_slot
  import fetch_line_sequencer_cfg_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 write_en,
  input  logic [TAG_BITS-1:0]  write_tag,
  input  logic [LINE_BITS-1:0] write_data,
  input  logic                 invalidate,
  input  logic [TAG_BITS-1:0]  cmp_tag_a,
  input  logic [TAG_BITS-1:0]  cmp_tag_b,
  output logic                 valid,
  output logic [LINE_BITS-1:0] data,
  output logic                 hit_a,
  output logic                 hit_b
);
  logic                 valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_q, tag_d;
  logic [LINE_BITS-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (invalidate) begin
      valid_d = 1'b0;
    end else if (write_en) begin
      valid_d = 1'b1;
      tag_d   = write_tag;
      data_d  = write_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign hit_a = valid_q && (tag_q == cmp_tag_a);
  assign hit_b = valid_q && (tag_q == cmp_tag_b);
endmodule

// File: rtl/fetch_line_sequencer.sv
// fetch_line_sequencer: two-slot line buffer for the fetch window, refilled one line at a time.
// Latency: resident lines return combinationally; a miss becomes a request on the next cycle.
// Backpressure: request held stable until memRequestReady; responses are never stalled.
// Ports: low/highFetchAddress -> low/highFetchData + low/highValid; redirect flushes;
//        memRequest{Valid,Ready,Address} out, memResponse{Valid,Data} in.
module fetch_line_sequencer
  import fetch_line_sequencer_pkg::*;
  import fetch_line_sequencer_cfg_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 redirect,
  input  logic [31:0]          lowFetchAddress,
  input  logic [31:0]          highFetchAddress,
  output logic [LINE_BITS-1:0] lowFetchData,
  output logic [LINE_BITS-1:0] highFetchData,
  output logic                 lowValid,
  output logic                 highValid,
  output logic                 memRequestValid,
  input  logic                 memRequestReady,
  output logic [31:0]          memRequestAddress,
  input  logic                 memResponseValid,
  input  logic [LINE_BITS-1:0] memResponseData
);
  FetchState   state_q, state_d;
  logic        mem_req_vld_q, mem_req_vld_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        victim_q, victim_d;

  logic [TAG_BITS-1:0]  low_tag, high_tag;
  logic [1:0]           slot_vld, low_hit, high_hit, slot_wr, slot_inv;
  logic [LINE_BITS-1:0] slot_data [2];
  logic                 low_miss, high_miss, victim_sel;
  logic                 addr_offset_unused;

  assign low_tag  = lowFetchAddress[31:OFFSET_BITS];
  assign high_tag = highFetchAddress[31:OFFSET_BITS];
  // Byte offsets within a line never affect which line is returned.
  assign addr_offset_unused = ^{lowFetchAddress[OFFSET_BITS-1:0], highFetchAddress[OFFSET_BITS-1:0]};

  for (genvar i = 0; i < 2; i++) begin : g_slot
    line_slot u_slot (
      .clock      (clock),
      .reset      (reset),
      .write_en   (slot_wr[i]),
      .write_tag  (req_addr_q[31:OFFSET_BITS]),
      .write_data (memResponseData),
      .invalidate (slot_inv[i]),
      .cmp_tag_a  (low_tag),
      .cmp_tag_b  (high_tag),
      .valid      (slot_vld[i]),
      .data       (slot_data[i]),
      .hit_a      (low_hit[i]),
      .hit_b      (high_hit[i])
    );
  end

  assign low_miss  = ~|low_hit;
  assign high_miss = ~|high_hit;

  // Hit path: a tag is never resident in both slots, so slot 0 first is only a tie-break.
  always_comb begin
    lowValid      = !low_miss && !redirect;
    highValid     = !high_miss && !redirect;
    lowFetchData  = '0;
    highFetchData = '0;
    if (lowValid)  lowFetchData  = low_hit[0]  ? slot_data[0] : slot_data[1];
    if (highValid) highFetchData = high_hit[0] ? slot_data[0] : slot_data[1];
  end

  // Victim: free slot first, then a slot neither port is using, else slot 0.
  always_comb begin
    victim_sel = 1'b0;
    if (!slot_vld[0])                    victim_sel = 1'b0;
    else if (!slot_vld[1])               victim_sel = 1'b1;
    else if (!low_hit[0] && !high_hit[0]) victim_sel = 1'b0;
    else if (!low_hit[1] && !high_hit[1]) victim_sel = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    victim_d   = victim_q;
    slot_wr    = '0;
    slot_inv   = {2{redirect}};
    unique case (state_q)
      FetchIdle: begin
        if (!redirect && (low_miss || high_miss)) begin
          req_addr_d           = {(low_miss ? low_tag : high_tag), {OFFSET_BITS{1'b0}}};
          victim_d             = victim_sel;
          slot_inv[victim_sel] = 1'b1;
          state_d              = FetchRequest;
        end
      end
      FetchRequest: begin
        if (memRequestReady) state_d = redirect ? FetchDrain : FetchWait;
        else if (redirect)   state_d = FetchKill;
      end
      FetchWait: begin
        if (memResponseValid) begin
          state_d = FetchIdle;
          if (!redirect) slot_wr[victim_q] = 1'b1;
        end else if (redirect) begin
          state_d = FetchDrain;
        end
      end
      // A killed request stays asserted until taken, then its response is swallowed.
      FetchKill:  if (memRequestReady)  state_d = FetchDrain;
      FetchDrain: if (memResponseValid) state_d = FetchIdle;
      default:    state_d = FetchIdle;
    endcase
    mem_req_vld_d = (state_d == FetchRequest) || (state_d == FetchKill);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= FetchIdle;
      mem_req_vld_q <= 1'b0;
      req_addr_q    <= '0;
      victim_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_vld_q <= mem_req_vld_d;
      req_addr_q    <= req_addr_d;
      victim_q      <= victim_d;
    end
  end

  assign memRequestValid   = mem_req_vld_q;
  assign memRequestAddress = req_addr_q;
endmodule
